// File: rtl/water_heater_controller.sv
// Heater controller: latches a wash target on a start edge, heats to it, soaks
// with hysteresis for a fixed time, then pulses done. A heating timeout latches a fault.
module water_heater_controller #(
    parameter int HEAT_TIMEOUT = 1000,
    parameter int HOLD_CYCLES  = 200,
    parameter int HYST         = 2,
    parameter int COLD_THRESH  = 10,
    parameter int TIMER_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [5:0] target_temp,
    input  logic [6:0] sensor_temp,
    input  logic       sensor_valid,
    output logic       heater_on,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEATING = 3'd1,
        HOLD    = 3'd2,
        DONE    = 3'd3,
        FAULT   = 3'd4
    } state_t;

    localparam logic [TIMER_W-1:0] HEAT_LAST = TIMER_W'(HEAT_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = '1;
    localparam logic [7:0]         HYST_8    = 8'(HYST);
    localparam logic [7:0]         COLD_8    = 8'(COLD_THRESH);

    state_t             state_q, state_nx;
    logic [TIMER_W-1:0] timer, timer_nx, timer_inc;
    logic [5:0]         target_q, target_nx;
    logic [6:0]         last_temp, temp_cur;
    logic               start_prev, start_edge;
    logic               heater_nx;
    logic [7:0]         temp8, tgt8, hold_low;

    // A valid sample is used in the same cycle it arrives.
    assign temp_cur   = sensor_valid ? sensor_temp : last_temp;
    assign temp8      = {1'b0, temp_cur};
    assign tgt8       = {2'b00, target_q};
    assign hold_low   = (tgt8 >= HYST_8) ? (tgt8 - HYST_8) : 8'd0;
    assign start_edge = start & ~start_prev;
    assign timer_inc  = (timer == TIMER_MAX) ? timer : timer + 1'b1;
    assign state      = state_q;

    always_comb begin
        state_nx  = state_q;
        heater_nx = heater_on;
        timer_nx  = timer;
        target_nx = target_q;
        case (state_q)
            IDLE: begin
                heater_nx = 1'b0;
                if (start_edge) begin
                    target_nx = target_temp;
                    timer_nx  = '0;
                    if ({2'b00, target_temp} <= COLD_8) begin
                        state_nx = DONE;
                    end else begin
                        state_nx  = HEATING;
                        heater_nx = 1'b1;
                    end
                end
            end
            HEATING: begin
                heater_nx = 1'b1;
                timer_nx  = timer_inc;
                if (temp8 >= tgt8) begin
                    state_nx  = HOLD;
                    timer_nx  = '0;
                    heater_nx = 1'b0;
                end else if (timer == HEAT_LAST) begin
                    state_nx  = FAULT;
                    heater_nx = 1'b0;
                end
            end
            HOLD: begin
                timer_nx = timer_inc;
                if (temp8 < hold_low) begin
                    heater_nx = 1'b1;
                end else if (temp8 >= tgt8) begin
                    heater_nx = 1'b0;
                end
                if (timer == HOLD_LAST) begin
                    state_nx  = DONE;
                    heater_nx = 1'b0;
                end
            end
            DONE: begin
                state_nx  = IDLE;
                heater_nx = 1'b0;
            end
            FAULT: begin
                heater_nx = 1'b0;
            end
            default: begin
                state_nx  = IDLE;
                heater_nx = 1'b0;
            end
        endcase
        if (abort) begin
            state_nx  = IDLE;
            heater_nx = 1'b0;
            timer_nx  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            heater_on  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            timer      <= '0;
            target_q   <= '0;
            last_temp  <= '0;
            start_prev <= 1'b0;
        end else begin
            state_q    <= state_nx;
            heater_on  <= heater_nx;
            busy       <= (state_nx == HEATING) || (state_nx == HOLD);
            done       <= (state_nx == DONE);
            fault      <= (state_nx == FAULT);
            timer      <= timer_nx;
            target_q   <= target_nx;
            last_temp  <= temp_cur;
            start_prev <= start;
        end
    end
endmodule

// File: tb/tb_water_heater_controller.sv
// Directed bench for water_heater_controller with hand-computed expectations.
module tb_water_heater_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [5:0] target_temp = '0;
    logic [6:0] sensor_temp = '0;
    logic       sensor_valid = 1'b0;
    logic       heater_on, busy, done, fault;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    water_heater_controller dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .target_temp(target_temp), .sensor_temp(sensor_temp),
        .sensor_valid(sensor_valid), .heater_on(heater_on), .busy(busy),
        .done(done), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n, hon;
        logic [6:0] samples [5];
        logic       exp_h   [5];
        samples = '{7'd40, 7'd39, 7'd38, 7'd37, 7'd40};
        exp_h   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state
        #2;
        check("rst_state", state, 0);
        check("rst_outs", {heater_on, busy, done, fault}, 0);
        cyc(2);
        reset = 1'b0;
        cyc(1);

        // 1: asynchronous reset mid-HEATING
        sensor_valid = 1'b1; sensor_temp = 7'd20; target_temp = 6'd40; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
        check("t1_heating_state", state, 1);
        check("t1_heater_on", heater_on, 1);
        #2 reset = 1'b1;
        #1;
        check("t1_async_state", state, 0);
        check("t1_async_outs", {heater_on, busy, done, fault}, 0);
        cyc(1);
        reset = 1'b0;
        cyc(1);

        // 2: heat to 60, hold, done
        target_temp = 6'd60; sensor_temp = 7'd20; start = 1'b1;
        hon = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            start = 1'b0;
            if (heater_on && state == 3'd1 && busy) hon++;
        end
        check("t2_heater_cycles", hon, 50);
        sensor_temp = 7'd60;
        cyc(1);
        check("t2_hold_state", state, 2);
        check("t2_hold_heater", heater_on, 0);
        n = 0;
        while (n < 400 && !done) begin
            cyc(1);
            n++;
        end
        check("t2_hold_len", n, 200);
        check("t2_done_state", state, 3);
        check("t2_busy_at_done", busy, 0);
        cyc(1);
        check("t2_done_pulse", {done, state}, 0);

        // 3: hysteresis in HOLD, target 40
        target_temp = 6'd40; sensor_temp = 7'd20; start = 1'b1;
        cyc(1);
        start = 1'b0; sensor_temp = 7'd40;
        cyc(1);
        check("t3_hold_state", state, 2);
        for (int i = 0; i < 5; i++) begin
            sensor_temp = samples[i];
            cyc(1);
            check($sformatf("t3_hyst_%0d", samples[i]), heater_on, exp_h[i]);
        end
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("t3_abort_state", state, 0);

        // 4: cold wash skips heating
        target_temp = 6'd10; start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("t4_done_state", state, 3);
        check("t4_done_hi", {done, heater_on, busy}, 3'b100);
        cyc(1);
        check("t4_idle", {state, done, heater_on}, 0);

        // 5: heating timeout
        target_temp = 6'd30; sensor_temp = 7'd20; start = 1'b1;
        cyc(1);
        start = 1'b0;
        n = 0;
        while (n < 1200 && state != 3'd4) begin
            cyc(1);
            n++;
        end
        check("t5_timeout_len", n, 1000);
        check("t5_fault_outs", {fault, heater_on, busy}, 3'b100);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        check("t5_start_ignored", state, 4);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("t5_abort_state", state, 0);
        check("t5_fault_clr", fault, 0);

        // 6: start held across DONE, then abort+start in HOLD
        target_temp = 6'd10; start = 1'b1;
        cyc(1);
        check("t6_done", state, 3);
        cyc(5);
        check("t6_no_rerun", {state, done, busy}, 0);
        start = 1'b0;
        cyc(1);
        target_temp = 6'd40; sensor_temp = 7'd20; start = 1'b1;
        cyc(1);
        start = 1'b0; sensor_temp = 7'd40;
        cyc(3);
        check("t6_hold", state, 2);
        abort = 1'b1; start = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("t6_abort_idle", {state, busy}, 0);
        cyc(3);
        check("t6_stays_idle", {state, busy, heater_on}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
